rx_bit_sampler: RTL and testbench

Oversampling front end of the UART receiver. Counts oversampling clock edges within each bit period, majority-votes three mid-bit samples of the serial line, and tracks the bit index within the frame. Drives `sampled_bit`, `finish_s` and `bit_cnt` directly into the downstream deserializer. The RX control FSM gates it through `enable`.

---
 rtl/rx_bit_sampler_if.sv | 34 +++
 rtl/rx_bit_sampler.sv | 94 +++++++++
 tb/tb_rx_bit_sampler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_bit_sampler_if.sv
// Signal bundle between the UART RX control side and the oversampling bit sampler.
// The control side drives line, ratio and enable; the sampler returns the voted bit and counters.
interface rx_bit_sampler_if;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       enable;
    logic       sampled_bit;
    logic       finish_s;
    logic [3:0] bit_cnt;
    logic [5:0] edge_cnt;
    logic       cfg_err;

    modport master (
        output RX_IN,
        output prescale,
        output enable,
        input  sampled_bit,
        input  finish_s,
        input  bit_cnt,
        input  edge_cnt,
        input  cfg_err
    );

    modport slave (
        input  RX_IN,
        input  prescale,
        input  enable,
        output sampled_bit,
        output finish_s,
        output bit_cnt,
        output edge_cnt,
        output cfg_err
    );
endinterface

// File: rtl/rx_bit_sampler.sv
// UART RX oversampling front end: counts clocks per bit, majority-votes three
// mid-bit samples and tracks the bit index within the frame.
module rx_bit_sampler #(
    parameter int unsigned FRAME_BITS   = 11,
    parameter int unsigned DEF_PRESCALE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    rx_bit_sampler_if.slave  bus
);

    localparam logic [5:0] DEF_P    = 6'(DEF_PRESCALE);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic [5:0] p_q, p_d;
    logic       cfg_err_q, cfg_err_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] shift_q, shift_d;
    logic       sampled_bit_q, sampled_bit_d;
    logic       finish_s_q, finish_s_d;

    logic       prescale_legal;
    logic [5:0] mid;
    logic       edge_last;
    logic       vote;

    assign prescale_legal = !bus.prescale[0] && (bus.prescale >= 6'd6) && (bus.prescale <= 6'd32);
    assign mid            = {1'b0, p_q[5:1]};
    assign edge_last      = (edge_cnt_q == p_q - 6'd1);
    // shift_q holds the two earlier samples; the third is taken straight off the line.
    assign vote           = (shift_q[1] & shift_q[0]) | (shift_q[1] & bus.RX_IN) | (shift_q[0] & bus.RX_IN);

    always_comb begin
        p_d           = p_q;
        cfg_err_d     = cfg_err_q;
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        sampled_bit_d = sampled_bit_q;
        finish_s_d    = 1'b0;

        if (!bus.enable) begin
            p_d        = prescale_legal ? bus.prescale : DEF_P;
            cfg_err_d  = !prescale_legal;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else begin
            if (edge_last) begin
                edge_cnt_d = '0;
                bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end

            if ((edge_cnt_q == mid - 6'd1) || (edge_cnt_q == mid)) begin
                shift_d = {shift_q[0], bus.RX_IN};
            end

            if (edge_cnt_q == mid + 6'd1) begin
                sampled_bit_d = vote;
                finish_s_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q           <= DEF_P;
            cfg_err_q     <= 1'b0;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            sampled_bit_q <= 1'b1;
            finish_s_q    <= 1'b0;
        end else begin
            p_q           <= p_d;
            cfg_err_q     <= cfg_err_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            sampled_bit_q <= sampled_bit_d;
            finish_s_q    <= finish_s_d;
        end
    end

    assign bus.sampled_bit = sampled_bit_q;
    assign bus.finish_s    = finish_s_q;
    assign bus.bit_cnt     = bit_cnt_q;
    assign bus.edge_cnt    = edge_cnt_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler: directed scenarios plus randomized
// frames, checked against a cycle-index arithmetic model of the bit timing.
module tb_rx_bit_sampler;

    localparam int FRAME = 11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_bit_sampler_if bus();

    rx_bit_sampler #(.FRAME_BITS(11), .DEF_PRESCALE(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int   vectors = 0;
    int   errors  = 0;
    logic exp_sb;
    int   mod_p;
    logic mod_err;
    logic rx_pat   [0:1023];
    int   pres_pat [0:1023];

    function automatic bit is_legal(input int v);
        return (v % 2 == 0) && (v >= 6) && (v <= 32);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return ((int'(a) + int'(b) + int'(c)) >= 2);
    endfunction

    task automatic model_reset();
        exp_sb  = 1'b1;
        mod_p   = 8;
        mod_err = 1'b0;
    endtask

    task automatic fill_pres(input int v);
        for (int i = 0; i < 1024; i++) pres_pat[i] = v;
    endtask

    // Idle cycles: counters must sit at zero, sampled_bit holds, ratio is latched.
    task automatic idle(input int n, input int pres);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.enable   = 1'b0;
            bus.prescale = 6'(pres);
            bus.RX_IN    = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus.edge_cnt !== 6'd0) begin
                errors++; $display("FAIL idle_edge_cnt: got %0d expected 0", bus.edge_cnt);
            end
            vectors++;
            if (bus.bit_cnt !== 4'd0) begin
                errors++; $display("FAIL idle_bit_cnt: got %0d expected 0", bus.bit_cnt);
            end
            vectors++;
            if (bus.finish_s !== 1'b0) begin
                errors++; $display("FAIL idle_finish_s: got %b expected 0", bus.finish_s);
            end
            vectors++;
            if (bus.sampled_bit !== exp_sb) begin
                errors++; $display("FAIL idle_sampled_bit: got %b expected %b", bus.sampled_bit, exp_sb);
            end
            vectors++;
            if (bus.cfg_err !== mod_err) begin
                errors++; $display("FAIL idle_cfg_err: got %b expected %b", bus.cfg_err, mod_err);
            end
            mod_p   = is_legal(pres) ? pres : 8;
            mod_err = !is_legal(pres);
        end
    endtask

    // Enabled run of ncyc cycles followed by one cycle with enable low.
    // Cycle k since enable rose: edge = k mod P, bit = (k div P) mod FRAME,
    // finish when edge = P/2+2 with the vote of the line in cycles k-3..k-1.
    task automatic run(input int ncyc, output int nfin);
        int p, m, exp_edge, exp_bit;
        logic exp_fin;
        p = mod_p;
        m = p / 2;
        nfin = 0;
        for (int k = 0; k <= ncyc; k++) begin
            @(posedge clk); #1;
            bus.enable   = (k < ncyc);
            bus.RX_IN    = rx_pat[k];
            bus.prescale = 6'(pres_pat[k]);
            @(negedge clk);
            exp_edge = k % p;
            exp_bit  = (k / p) % FRAME;
            exp_fin  = (exp_edge == m + 2);
            if (exp_fin) exp_sb = maj3(rx_pat[k-3], rx_pat[k-2], rx_pat[k-1]);
            vectors++;
            if (bus.edge_cnt !== 6'(exp_edge)) begin
                errors++; $display("FAIL edge_cnt k=%0d P=%0d: got %0d expected %0d", k, p, bus.edge_cnt, exp_edge);
            end
            vectors++;
            if (bus.bit_cnt !== 4'(exp_bit)) begin
                errors++; $display("FAIL bit_cnt k=%0d P=%0d: got %0d expected %0d", k, p, bus.bit_cnt, exp_bit);
            end
            vectors++;
            if (bus.finish_s !== exp_fin) begin
                errors++; $display("FAIL finish_s k=%0d P=%0d: got %b expected %b", k, p, bus.finish_s, exp_fin);
            end
            vectors++;
            if (bus.sampled_bit !== exp_sb) begin
                errors++; $display("FAIL sampled_bit k=%0d P=%0d: got %b expected %b", k, p, bus.sampled_bit, exp_sb);
            end
            vectors++;
            if (bus.cfg_err !== mod_err) begin
                errors++; $display("FAIL cfg_err k=%0d: got %b expected %b", k, bus.cfg_err, mod_err);
            end
            if (bus.finish_s === 1'b1) nfin++;
        end
        mod_p   = is_legal(pres_pat[ncyc]) ? pres_pat[ncyc] : 8;
        mod_err = !is_legal(pres_pat[ncyc]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.prescale = 6'd8; bus.RX_IN = 1'b1;
        model_reset();
        #12;
        vectors++;
        if ({bus.sampled_bit, bus.finish_s, bus.bit_cnt, bus.edge_cnt, bus.cfg_err} !== {1'b1, 1'b0, 4'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got sb=%b fin=%b bit=%0d edge=%0d err=%b expected 1 0 0 0 0",
                     bus.sampled_bit, bus.finish_s, bus.bit_cnt, bus.edge_cnt, bus.cfg_err);
        end
        @(negedge clk); rst_n = 1'b1;
        idle(2, 8);
    endtask

    task automatic test_basic_p8();
        int nfin;
        idle(1, 8);
        fill_pres(8);
        for (int i = 0; i < 1024; i++) rx_pat[i] = (i < 8) ? 1'b0 : 1'b1;
        run(10, nfin);
        vectors++;
        if (nfin !== 1) begin
            errors++; $display("FAIL basic_p8_pulses: got %0d expected 1", nfin);
        end
        idle(1, 8);
    endtask

    task automatic test_frame_a5();
        int nfin;
        logic [10:0] frame;
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
        idle(1, 16);
        fill_pres(16);
        for (int i = 0; i < 1024; i++) rx_pat[i] = (i < 176) ? frame[i / 16] : 1'b1;
        run(180, nfin);
        vectors++;
        if (nfin !== 11) begin
            errors++; $display("FAIL frame_a5_pulses: got %0d expected 11", nfin);
        end
        idle(1, 16);
    endtask

    task automatic test_glitch();
        int nfin;
        idle(1, 8);
        fill_pres(8);
        for (int i = 0; i < 1024; i++) rx_pat[i] = 1'b1;
        rx_pat[4]  = 1'b0;
        rx_pat[11] = 1'b0;
        rx_pat[12] = 1'b0;
        run(16, nfin);
        vectors++;
        if (bus.sampled_bit !== 1'b0) begin
            errors++; $display("FAIL glitch_two_low: got %b expected 0", bus.sampled_bit);
        end
        idle(1, 8);
    endtask

    task automatic test_prescale();
        int nfin;
        for (int i = 0; i < 1024; i++) rx_pat[i] = 1'($urandom_range(0, 1));
        fill_pres(7);
        idle(1, 7);
        run(20, nfin);
        vectors++;
        if (nfin !== 2) begin
            errors++; $display("FAIL prescale7_pulses: got %0d expected 2", nfin);
        end
        foreach (pres_pat[i]) pres_pat[i] = 32;
        idle(1, 32);
        run(40, nfin);
        foreach (pres_pat[i]) pres_pat[i] = (i < 20) ? 16 : 8;
        idle(1, 16);
        run(40, nfin);
        fill_pres(8);
        run(20, nfin);
        fill_pres(34);
        idle(1, 34);
        run(12, nfin);
        fill_pres(4);
        idle(1, 4);
        run(12, nfin);
        idle(1, 8);
    endtask

    task automatic test_enable_drop();
        int nfin;
        idle(1, 8);
        fill_pres(8);
        for (int i = 0; i < 1024; i++) rx_pat[i] = 1'($urandom_range(0, 1));
        run(29, nfin);
        idle(2, 8);
        for (int i = 0; i < 1024; i++) rx_pat[i] = ~rx_pat[i];
        run(16, nfin);
        run(6, nfin);
        idle(2, 8);
    endtask

    task automatic test_reset_mid();
        int nfin;
        idle(1, 16);
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            bus.enable = 1'b1; bus.RX_IN = 1'b0; bus.prescale = 6'd16;
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.bit_cnt !== 4'd4 || bus.sampled_bit !== 1'b0) begin
            errors++; $display("FAIL pre_reset_state: got bit=%0d sb=%b expected 4 0", bus.bit_cnt, bus.sampled_bit);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.sampled_bit, bus.finish_s, bus.bit_cnt, bus.edge_cnt, bus.cfg_err} !== {1'b1, 1'b0, 4'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_values: got sb=%b fin=%b bit=%0d edge=%0d err=%b expected 1 0 0 0 0",
                     bus.sampled_bit, bus.finish_s, bus.bit_cnt, bus.edge_cnt, bus.cfg_err);
        end
        @(negedge clk); @(negedge clk);
        vectors++;
        if (bus.edge_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_hold_edge_cnt: got %0d expected 0", bus.edge_cnt);
        end
        bus.enable = 1'b0;
        rst_n = 1'b1;
        model_reset();
        idle(2, 16);
        fill_pres(16);
        for (int i = 0; i < 1024; i++) rx_pat[i] = 1'($urandom_range(0, 1));
        run(20, nfin);
    endtask

    task automatic test_random();
        int nfin, pres, p, ncyc;
        logic bitval;
        for (int it = 0; it < 20; it++) begin
            pres = (it % 4 == 3) ? int'($urandom_range(0, 63)) : 2 * int'($urandom_range(3, 16));
            fill_pres(pres);
            idle(1 + int'($urandom_range(0, 2)), pres);
            p = mod_p;
            ncyc = int'($urandom_range(10, 250));
            bitval = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                if (i % p == 0) bitval = 1'($urandom_range(0, 1));
                rx_pat[i] = ($urandom_range(0, 7) == 0) ? ~bitval : bitval;
            end
            if (it % 5 == 4) pres_pat[ncyc] = 2 * int'($urandom_range(3, 16));
            run(ncyc, nfin);
        end
        idle(1, 8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_p8();
        test_frame_a5();
        test_glitch();
        test_prescale();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
